barrett_reduce_ctrl: RTL and testbench

- Initiator side of the middle-bit multiplier interface. Accepts a 2K-bit operand x and reduces it modulo the fixed modulus MOD using Barrett reduction.
- Drives an external middle-bit multiplier (en pulse, fixed 3-cycle latency, K-bit middle slice result) to obtain the quotient estimate q.
- Finishes the reduction locally: low-half product, subtraction, then correction.
- Sits between the modular-arithmetic datapath producers and consumers, with valid/ready handshakes on both sides.

---
 rtl/barrett_reduce_ctrl_pkg.sv | 25 ++
 rtl/barrett_corr_step.sv | 16 +
 rtl/barrett_reduce_ctrl.sv | 141 ++++++++++++++
 tb/tb_barrett_reduce_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/barrett_reduce_ctrl_pkg.sv
// Shared state type and default configuration for the Barrett reduction controller.
// Default modulus is 2^77 + 1, for which floor(2^156 / MOD) = 2^79 - 4.
package barrett_reduce_ctrl_pkg;

    localparam int unsigned BARRETT_K       = 78;
    localparam int unsigned BARRETT_MUL_W   = BARRETT_K + 2;
    localparam int unsigned BARRETT_MUL_LAT = 3;
    localparam int unsigned BARRETT_RW      = BARRETT_K + 2;
    localparam int unsigned BARRETT_XW      = 2 * BARRETT_K;

    localparam logic [BARRETT_K-1:0] BARRETT_MOD = {1'b1, {(BARRETT_K-2){1'b0}}, 1'b1};
    localparam logic [BARRETT_K:0]   BARRETT_MU  = {{(BARRETT_K-1){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_QM,
        ST_SUB,
        ST_CORR,
        ST_DONE
    } barrett_state_e;

endpackage

// File: rtl/barrett_corr_step.sv
// One Barrett correction step: subtract the modulus when the residue is not yet reduced.
module barrett_corr_step
    import barrett_reduce_ctrl_pkg::*;
#(
    parameter int unsigned  W   = BARRETT_RW,
    parameter logic [W-1:0] MOD = W'(BARRETT_MOD)
) (
    input  logic [W-1:0] i_r,
    output logic [W-1:0] o_r,
    output logic         o_ge
);

    assign o_ge = (i_r >= MOD);
    assign o_r  = o_ge ? (i_r - MOD) : i_r;

endmodule

// File: rtl/barrett_reduce_ctrl.sv
// Barrett reduction controller: issues x's upper bits to an external middle-bit
// multiplier, then finishes x mod MOD locally. Macro BARRETT_EARLY_EXIT_EN enables early CORR exit.
module barrett_reduce_ctrl
    import barrett_reduce_ctrl_pkg::*;
#(
    parameter int unsigned  K       = BARRETT_K,
    parameter int unsigned  MUL_W   = BARRETT_MUL_W,
    parameter logic [K-1:0] MOD     = K'(BARRETT_MOD),
    parameter logic [K:0]   MU      = (K+1)'(BARRETT_MU),
    parameter int unsigned  MUL_LAT = BARRETT_MUL_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*K-1:0]   in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     out_r,
    output logic             out_err,
    output logic             mul_en,
    output logic [MUL_W-1:0] mul_a,
    output logic [MUL_W-1:0] mul_b,
    input  logic [K-1:0]     mul_res
);

    localparam int unsigned RW = K + 2;
    localparam int unsigned XW = 2 * K;
    localparam int unsigned CW = 8;

    localparam logic [RW-1:0] MOD_RW = {2'b00, MOD};

    barrett_state_e r_state;
    barrett_state_e w_state_nxt;

    logic [RW-1:0]    r_x_lo;
    logic [MUL_W-1:0] r_mul_a;
    logic [MUL_W-1:0] r_mul_b;
    logic [K-1:0]     r_q;
    logic [RW-1:0]    r_qm;
    logic [RW-1:0]    r_r;
    logic [CW-1:0]    r_cnt;

    logic [RW-1:0]    w_qm;
    logic [RW-1:0]    w_sub;
    logic [RW-1:0]    w_step;
    logic             w_ge;

    // Only the low RW bits of q*MOD and x matter: the true residue is < 3*MOD < 2^RW.
    assign w_qm  = {2'b00, r_q} * MOD_RW;
    assign w_sub = r_x_lo - r_qm;

    barrett_corr_step #(
        .W   (RW),
        .MOD (MOD_RW)
    ) u_corr_step (
        .i_r  (r_r),
        .o_r  (w_step),
        .o_ge (w_ge)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (in_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE:   w_state_nxt = ST_WAIT;
            ST_WAIT:    if (r_cnt == '0) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_QM;
            ST_QM:      w_state_nxt = ST_SUB;
`ifdef BARRETT_EARLY_EXIT_EN
            ST_SUB:     w_state_nxt = (w_sub < MOD_RW) ? ST_DONE : ST_CORR;
            ST_CORR:    if ((r_cnt == '0) || (w_step < MOD_RW)) w_state_nxt = ST_DONE;
`else
            ST_SUB:     w_state_nxt = ST_CORR;
            ST_CORR:    if (r_cnt == '0) w_state_nxt = ST_DONE;
`endif
            ST_DONE:    if (out_ready) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (r_state == ST_IDLE);
        out_valid = rst_n && (r_state == ST_DONE);
        mul_en    = rst_n && (r_state == ST_ISSUE);
        out_r     = '0;
        out_err   = 1'b0;
        if (r_state == ST_DONE) begin
            out_r   = r_r[K-1:0];
            out_err = w_ge;
        end
    end

    assign mul_a = r_mul_a;
    assign mul_b = r_mul_b;

    // One down-counter serves both the WAIT span and the fixed CORR span.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x_lo  <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_q     <= '0;
            r_qm    <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x_lo  <= in_x[RW-1:0];
                        r_mul_a <= in_x[XW-1:K-2];
                        r_mul_b <= MUL_W'(MU);
                    end
                end
                ST_ISSUE:   r_cnt <= CW'(MUL_LAT - 2);
                ST_WAIT:    r_cnt <= r_cnt - CW'(1);
                ST_CAPTURE: r_q   <= mul_res;
                ST_QM:      r_qm  <= w_qm;
                ST_SUB: begin
                    r_r   <= w_sub;
                    r_cnt <= CW'(1);
                end
                ST_CORR: begin
                    r_r   <= w_step;
                    r_cnt <= r_cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_reduce_ctrl.sv
// Randomized self-checking bench for barrett_reduce_ctrl (K=8, MOD=251) with a
// behavioural 3-cycle middle-bit multiplier; expected latency follows BARRETT_EARLY_EXIT_EN.
module tb_barrett_reduce_ctrl;

    localparam int unsigned K      = 8;
    localparam int unsigned MUL_W  = 10;
    localparam int unsigned MODV   = 251;
    localparam int unsigned MUV    = 261;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2*K-1:0]   in_x;
    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     out_r;
    logic             out_err;
    logic             mul_en;
    logic [MUL_W-1:0] mul_a;
    logic [MUL_W-1:0] mul_b;
    logic [K-1:0]     mul_res;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned last_wait;

    always #5 clk = ~clk;

    barrett_reduce_ctrl #(
        .K       (K),
        .MUL_W   (MUL_W),
        .MOD     (8'd251),
        .MU      (9'd261),
        .MUL_LAT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_err   (out_err),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_res   (mul_res)
    );

    // Multiplier model: product registered on the mul_en edge, two more stages,
    // garbage in every slot that was not started so mistimed captures show up.
    logic [2*MUL_W-1:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= mul_en ? (mul_a * mul_b) : (2*MUL_W)'($urandom);
        p2 <= p1;
        p3 <= p2;
    end
    assign mul_res = p3[2*K+1:K+2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned exp_latency(input int unsigned x);
`ifdef BARRETT_EARLY_EXIT_EN
        int unsigned q;
        q = ((x >> (K-2)) * MUV) >> (K+2);
        return 7 + (x - q * MODV) / MODV;
`else
        return 9 + (x & 0);
`endif
    endfunction

    task automatic run_op(input int unsigned x, input int unsigned hold);
        int unsigned lat, en_cnt, en_first, busy_ready, w;
        logic [MUL_W-1:0] a_seen, b_seen;
        lat = 0; en_cnt = 0; en_first = 0; busy_ready = 0;
        a_seen = '0; b_seen = '0;
        for (w = 0; w < 50; w++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        last_wait = w;
        check_eq("accept_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_x      = 16'(x);
        out_ready = (hold == 0);
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mul_en) begin
                en_cnt++;
                if (en_first == 0) begin
                    en_first = i;
                    a_seen   = mul_a;
                    b_seen   = mul_b;
                end
            end
            if (out_valid) begin
                lat = i;
                break;
            end
            if (in_ready) busy_ready++;
            in_valid = 1'($urandom_range(0, 1));
            in_x     = 16'($urandom);
        end
        in_valid = 1'b0;
        check_eq("latency", lat, exp_latency(x));
        check_eq("out_r", out_r, x % MODV);
        check_eq("out_err", out_err, 0);
        check_eq("mul_en_count", en_cnt, 1);
        check_eq("mul_en_cycle", en_first, 1);
        check_eq("mul_a", a_seen, x >> (K-2));
        check_eq("mul_b", b_seen, MUV);
        check_eq("busy_in_ready", busy_ready, 0);
        for (int h = 0; h < int'(hold); h++) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_r", out_r, x % MODV);
            check_eq("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_in_ready", in_ready, 1);
        check_eq("post_out_valid", out_valid, 0);
    endtask

    task automatic run_abort(input int unsigned x);
        check_eq("abort_accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_x     = 16'(x);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_mul_en", mul_en, 0);
        check_eq("abort_in_ready_rst", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_mul_a", mul_a, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_r", out_r, 0);
        check_eq("rst_out_err", out_err, 0);
        check_eq("rst_mul_en", mul_en, 0);
        check_eq("rst_mul_a", mul_a, 0);
        check_eq("rst_mul_b", mul_b, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_in_ready", in_ready, 1);

        run_op(0, 0);
        run_op(63000, 0);
        run_op(62500, 0);
        run_op(251, 0);
        run_op($urandom_range(0, 63000), 5);
        run_op(1234, 0);
        check_eq("back_to_back_wait", last_wait, 0);

        run_abort(40000);
        run_op(62500, 0);

        for (int n = 0; n < 25; n++) begin
            run_op($urandom_range(0, 63000), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
